// File: rtl/multsigned_acc_array.sv
// Pipelined signed/unsigned multiply-accumulate array.
// Stage P registers one product per lane. Stage A adds it into a saturating
// per-lane accumulator. A finished group moves into output register O and
// waits there until the consumer takes it.
module multsigned_acc_array #(
    parameter int IN_SIZE_0  = 4,
    parameter int IN_SIZE_1  = 8,
    parameter int SIZE_ARRAY = 8,
    parameter int ACC_SIZE   = 20,
    parameter int CNT_SIZE   = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  last_i,
    input  logic                  signed_i,
    input  logic [IN_SIZE_0-1:0]  in_0_i [0:SIZE_ARRAY-1],
    input  logic [IN_SIZE_1-1:0]  in_1_i [0:SIZE_ARRAY-1],
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [ACC_SIZE-1:0]   out_o  [0:SIZE_ARRAY-1],
    output logic [SIZE_ARRAY-1:0] sat_o,
    output logic [CNT_SIZE-1:0]   beats_o
);

    localparam int PW = IN_SIZE_0 + IN_SIZE_1;
    // The sum is one bit wider than the accumulator so that overflow shows up
    // as a disagreement between its top two bits.
    localparam int SW = ACC_SIZE + 1;
    localparam logic [CNT_SIZE-1:0] CNT_MAX     = {CNT_SIZE{1'b1}};
    localparam logic [ACC_SIZE-1:0] ACC_POS_MAX = {1'b0, {(ACC_SIZE-1){1'b1}}};
    localparam logic [ACC_SIZE-1:0] ACC_NEG_MIN = {1'b1, {(ACC_SIZE-1){1'b0}}};

    // A narrower accumulator could overflow the one-bit-wider sum in a single add.
    if (ACC_SIZE < IN_SIZE_0 + IN_SIZE_1 + 2) begin : g_acc_too_narrow
        $error("multsigned_acc_array: ACC_SIZE must be at least IN_SIZE_0+IN_SIZE_1+2");
    end

    // Stage P registers
    logic                p_vld_q,    p_vld_d;
    logic                p_last_q,   p_last_d;
    logic                p_signed_q, p_signed_d;
    logic [PW-1:0]       p_prod_q [0:SIZE_ARRAY-1];
    logic [PW-1:0]       p_prod_d [0:SIZE_ARRAY-1];

    // Stage A registers
    logic [ACC_SIZE-1:0] acc_q [0:SIZE_ARRAY-1];
    logic [ACC_SIZE-1:0] acc_d [0:SIZE_ARRAY-1];
    logic [SIZE_ARRAY-1:0] sat_q, sat_d;
    logic [CNT_SIZE-1:0] cnt_q, cnt_d;

    // Output register O
    logic                o_vld_q, o_vld_d;
    logic [ACC_SIZE-1:0] o_acc_q [0:SIZE_ARRAY-1];
    logic [ACC_SIZE-1:0] o_acc_d [0:SIZE_ARRAY-1];
    logic [SIZE_ARRAY-1:0] o_sat_q, o_sat_d;
    logic [CNT_SIZE-1:0] o_cnt_q, o_cnt_d;

    // Combinational datapath
    logic [PW-1:0]       opa_ext  [0:SIZE_ARRAY-1];
    logic [PW-1:0]       opb_ext  [0:SIZE_ARRAY-1];
    logic [PW-1:0]       prod_now [0:SIZE_ARRAY-1];
    logic [SW-1:0]       prod_ext [0:SIZE_ARRAY-1];
    logic [SW-1:0]       lane_sum [0:SIZE_ARRAY-1];
    logic [ACC_SIZE-1:0] acc_next [0:SIZE_ARRAY-1];
    logic [SIZE_ARRAY-1:0] clamp;
    logic [CNT_SIZE-1:0] cnt_inc;

    logic stall;
    logic accept;
    logic p_advance;

    // A last beat may only leave P once O is empty or is being drained in the
    // same cycle. Non-last beats never touch O, so they never wait.
    assign stall     = p_vld_q && p_last_q && o_vld_q && !out_ready_i;
    assign ready_o   = !p_vld_q || !stall;
    assign accept    = valid_i && ready_o;
    assign p_advance = p_vld_q && !stall;

    // Extend both operands to the full product width and multiply per lane.
    always_comb begin
        for (int i = 0; i < SIZE_ARRAY; i++) begin
            opa_ext[i]  = signed_i ? {{IN_SIZE_1{in_0_i[i][IN_SIZE_0-1]}}, in_0_i[i]}
                                   : {{IN_SIZE_1{1'b0}}, in_0_i[i]};
            opb_ext[i]  = signed_i ? {{IN_SIZE_0{in_1_i[i][IN_SIZE_1-1]}}, in_1_i[i]}
                                   : {{IN_SIZE_0{1'b0}}, in_1_i[i]};
            prod_now[i] = opa_ext[i] * opb_ext[i];
        end
    end

    // P loads on accept, empties when its beat moves on without a replacement,
    // and otherwise holds.
    always_comb begin
        p_vld_d    = p_vld_q;
        p_last_d   = p_last_q;
        p_signed_d = p_signed_q;
        p_prod_d   = p_prod_q;
        if (accept) begin
            p_vld_d    = 1'b1;
            p_last_d   = last_i;
            p_signed_d = signed_i;
            p_prod_d   = prod_now;
        end else if (p_advance) begin
            p_vld_d = 1'b0;
        end
    end

    // Add the registered product into each lane, then clamp on overflow.
    always_comb begin
        clamp = '0;
        for (int i = 0; i < SIZE_ARRAY; i++) begin
            prod_ext[i] = p_signed_q ? {{(SW-PW){p_prod_q[i][PW-1]}}, p_prod_q[i]}
                                     : {{(SW-PW){1'b0}}, p_prod_q[i]};
            lane_sum[i] = {acc_q[i][ACC_SIZE-1], acc_q[i]} + prod_ext[i];
            clamp[i]    = lane_sum[i][SW-1] ^ lane_sum[i][SW-2];
            if (clamp[i]) begin
                acc_next[i] = lane_sum[i][SW-1] ? ACC_NEG_MIN : ACC_POS_MAX;
            end else begin
                acc_next[i] = lane_sum[i][ACC_SIZE-1:0];
            end
        end
        cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    end

    // A last beat hands the completed group to O and restarts the accumulator
    // from zero in the same edge. O empties when drained and nothing replaces it.
    always_comb begin
        acc_d   = acc_q;
        sat_d   = sat_q;
        cnt_d   = cnt_q;
        o_vld_d = o_vld_q && !out_ready_i;
        o_acc_d = o_acc_q;
        o_sat_d = o_sat_q;
        o_cnt_d = o_cnt_q;
        if (p_advance) begin
            if (p_last_q) begin
                o_vld_d = 1'b1;
                o_acc_d = acc_next;
                o_sat_d = sat_q | clamp;
                o_cnt_d = cnt_inc;
                for (int i = 0; i < SIZE_ARRAY; i++) begin
                    acc_d[i] = '0;
                end
                sat_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = acc_next;
                sat_d = sat_q | clamp;
                cnt_d = cnt_inc;
            end
        end
    end

    // Product stage register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_vld_q    <= 1'b0;
            p_last_q   <= 1'b0;
            p_signed_q <= 1'b0;
            for (int i = 0; i < SIZE_ARRAY; i++) begin
                p_prod_q[i] <= '0;
            end
        end else begin
            p_vld_q    <= p_vld_d;
            p_last_q   <= p_last_d;
            p_signed_q <= p_signed_d;
            p_prod_q   <= p_prod_d;
        end
    end

    // Accumulator, sticky saturation flags and beat counter.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < SIZE_ARRAY; i++) begin
                acc_q[i] <= '0;
            end
            sat_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            sat_q <= sat_d;
            cnt_q <= cnt_d;
        end
    end

    // Output register holding one finished group.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            o_vld_q <= 1'b0;
            for (int i = 0; i < SIZE_ARRAY; i++) begin
                o_acc_q[i] <= '0;
            end
            o_sat_q <= '0;
            o_cnt_q <= '0;
        end else begin
            o_vld_q <= o_vld_d;
            o_acc_q <= o_acc_d;
            o_sat_q <= o_sat_d;
            o_cnt_q <= o_cnt_d;
        end
    end

    assign out_valid_o = o_vld_q;
    assign out_o       = o_acc_q;
    assign sat_o       = o_sat_q;
    assign beats_o     = o_cnt_q;

endmodule

// File: tb/tb_multsigned_acc_array.sv
// Self-checking bench for multsigned_acc_array. The accumulator is set to its
// narrowest legal width so that saturation is easy to reach.
module tb_multsigned_acc_array;

    localparam int IN0     = 4;
    localparam int IN1     = 8;
    localparam int LANES   = 8;
    localparam int ACC_W   = 14;
    localparam int CNT_W   = 8;
    localparam int ACC_MAX = (1 << (ACC_W - 1)) - 1;
    localparam int ACC_MIN = -(1 << (ACC_W - 1));
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [LANES-1:0][ACC_W-1:0] acc;
        logic [LANES-1:0]            sat;
        logic [CNT_W-1:0]            beats;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic             last_i = 1'b0;
    logic             signed_i = 1'b0;
    logic [IN0-1:0]   in_0 [0:LANES-1];
    logic [IN1-1:0]   in_1 [0:LANES-1];
    logic             out_valid_o;
    logic             out_ready_i = 1'b1;
    logic [ACC_W-1:0] out_o [0:LANES-1];
    logic [LANES-1:0] sat_o;
    logic [CNT_W-1:0] beats_o;

    int n_cmp = 0;
    int n_bad = 0;
    int stall_cycles = 0;

    res_t exp_q[$];
    res_t rcv_q[$];

    // Reference model state: per-lane integer running sums of the open group.
    int               run_sum [LANES];
    logic [LANES-1:0] run_sat;
    int               run_cnt;

    multsigned_acc_array #(
        .IN_SIZE_0 (IN0),
        .IN_SIZE_1 (IN1),
        .SIZE_ARRAY(LANES),
        .ACC_SIZE  (ACC_W),
        .CNT_SIZE  (CNT_W)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .last_i     (last_i),
        .signed_i   (signed_i),
        .in_0_i     (in_0),
        .in_1_i     (in_1),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .out_o      (out_o),
        .sat_o      (sat_o),
        .beats_o    (beats_o)
    );

    always #5 clk = ~clk;

    // Abort a hung run.
    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Capture every result the consumer takes.
    always @(negedge clk) begin
        if (rst_n && out_valid_o && out_ready_i) begin
            res_t r;
            for (int i = 0; i < LANES; i++) r.acc[i] = out_o[i];
            r.sat   = sat_o;
            r.beats = beats_o;
            rcv_q.push_back(r);
        end
    end

    function automatic void model_clear();
        for (int i = 0; i < LANES; i++) run_sum[i] = 0;
        run_sat = '0;
        run_cnt = 0;
    endfunction

    // Add one accepted beat using plain integer arithmetic.
    function automatic void model_accept(input bit last, input bit sgn);
        res_t r;
        int a;
        int b;
        for (int i = 0; i < LANES; i++) begin
            a = int'(in_0[i]);
            b = int'(in_1[i]);
            if (sgn && a >= (1 << (IN0 - 1))) a -= (1 << IN0);
            if (sgn && b >= (1 << (IN1 - 1))) b -= (1 << IN1);
            run_sum[i] += a * b;
            if (run_sum[i] > ACC_MAX) begin
                run_sum[i] = ACC_MAX;
                run_sat[i] = 1'b1;
            end else if (run_sum[i] < ACC_MIN) begin
                run_sum[i] = ACC_MIN;
                run_sat[i] = 1'b1;
            end
        end
        if (run_cnt < CNT_MAX) run_cnt++;
        if (last) begin
            for (int i = 0; i < LANES; i++) r.acc[i] = ACC_W'(run_sum[i]);
            r.sat   = run_sat;
            r.beats = CNT_W'(run_cnt);
            exp_q.push_back(r);
            model_clear();
        end
    endfunction

    task automatic set_lanes(input logic [IN0-1:0] a, input logic [IN1-1:0] b);
        for (int i = 0; i < LANES; i++) begin
            in_0[i] = a;
            in_1[i] = b;
        end
    endtask

    // Offer one beat and hold it until it is accepted. The model sees the beat
    // on the edge where it is accepted.
    task automatic send_beat(input bit last, input bit sgn);
        bit rdy;
        bit done = 1'b0;
        int tries = 0;
        valid_i  = 1'b1;
        last_i   = last;
        signed_i = sgn;
        while (!done) begin
            @(negedge clk);
            rdy = ready_o;
            @(posedge clk);
            if (rdy) begin
                model_accept(last, sgn);
                done = 1'b1;
            end else begin
                tries++;
                stall_cycles++;
                if (tries > 200) begin
                    n_cmp++;
                    n_bad++;
                    $display("[TB] FAIL accept_timeout: beat not accepted after %0d cycles", tries);
                    done = 1'b1;
                end
            end
        end
        #1 valid_i = 1'b0;
    endtask

    task automatic wait_results(input int n);
        int cyc = 0;
        while (rcv_q.size() < n && cyc < 600) begin
            @(posedge clk);
            cyc++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic start_test();
        valid_i     = 1'b0;
        out_ready_i = 1'b1;
        set_lanes('0, '0);
        repeat (3) @(posedge clk);
        #1;
        rcv_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        set_lanes('0, '0);
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("[TB] FAIL reset_ready: got %b need 1", ready_o); end
        n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL reset_valid: got %b need 0", out_valid_o); end
        n_cmp++; if (sat_o !== '0) begin n_bad++; $display("[TB] FAIL reset_sat: got %h need 0", sat_o); end
        n_cmp++; if (beats_o !== '0) begin n_bad++; $display("[TB] FAIL reset_beats: got %0d need 0", beats_o); end
        for (int i = 0; i < LANES; i++) begin
            n_cmp++; if (out_o[i] !== '0) begin n_bad++; $display("[TB] FAIL reset_out lane %0d: got %h need 0", i, out_o[i]); end
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_single_signed();
        start_test();
        in_0[0] = 4'b1001;
        in_1[0] = 8'd127;
        send_beat(1'b1, 1'b1);
        @(negedge clk);
        n_cmp++; if (out_valid_o !== 1'b0) begin n_bad++; $display("[TB] FAIL latency_early: valid got %b need 0", out_valid_o); end
        @(negedge clk);
        n_cmp++; if (out_valid_o !== 1'b1) begin n_bad++; $display("[TB] FAIL latency_valid: got %b need 1", out_valid_o); end
        n_cmp++; if (out_o[0] !== ACC_W'(-889)) begin n_bad++; $display("[TB] FAIL single_signed_out: got %0d need -889", $signed(out_o[0])); end
        n_cmp++; if (beats_o !== 8'd1) begin n_bad++; $display("[TB] FAIL single_signed_beats: got %0d need 1", beats_o); end
        n_cmp++; if (sat_o !== '0) begin n_bad++; $display("[TB] FAIL single_signed_sat: got %h need 0", sat_o); end
        wait_results(1);
        n_cmp++; if (rcv_q.size() != 1) begin n_bad++; $display("[TB] FAIL single_signed_count: got %0d need 1", rcv_q.size()); end
    endtask

    task automatic test_unsigned_signed();
        start_test();
        in_0[0] = 4'hF;
        in_1[0] = 8'hFF;
        send_beat(1'b1, 1'b0);
        send_beat(1'b1, 1'b1);
        wait_results(2);
        n_cmp++; if (rcv_q.size() != 2) begin n_bad++; $display("[TB] FAIL mode_count: got %0d need 2", rcv_q.size()); end
        if (rcv_q.size() >= 2) begin
            n_cmp++; if (rcv_q[0].acc[0] !== 14'd3825) begin n_bad++; $display("[TB] FAIL unsigned_out: got %0d need 3825", rcv_q[0].acc[0]); end
            n_cmp++; if (rcv_q[1].acc[0] !== 14'd1) begin n_bad++; $display("[TB] FAIL signed_minus1_out: got %0d need 1", $signed(rcv_q[1].acc[0])); end
            n_cmp++; if (rcv_q[1].beats !== 8'd1) begin n_bad++; $display("[TB] FAIL signed_minus1_beats: got %0d need 1", rcv_q[1].beats); end
        end
    endtask

    task automatic test_saturation();
        start_test();
        set_lanes(4'h8, 8'h80);
        for (int b = 0; b < 8; b++) send_beat(b == 7, 1'b1);
        set_lanes(4'd2, 8'd3);
        send_beat(1'b1, 1'b1);
        wait_results(2);
        n_cmp++; if (rcv_q.size() != 2) begin n_bad++; $display("[TB] FAIL sat_count: got %0d need 2", rcv_q.size()); end
        if (rcv_q.size() >= 2) begin
            n_cmp++; if (rcv_q[0].acc[0] !== 14'd8191) begin n_bad++; $display("[TB] FAIL sat_out: got %0d need 8191", rcv_q[0].acc[0]); end
            n_cmp++; if (rcv_q[0].sat !== 8'hFF) begin n_bad++; $display("[TB] FAIL sat_flag: got %h need ff", rcv_q[0].sat); end
            n_cmp++; if (rcv_q[0].beats !== 8'd8) begin n_bad++; $display("[TB] FAIL sat_beats: got %0d need 8", rcv_q[0].beats); end
            n_cmp++; if (rcv_q[1].acc[0] !== 14'd6) begin n_bad++; $display("[TB] FAIL after_sat_out: got %0d need 6", rcv_q[1].acc[0]); end
            n_cmp++; if (rcv_q[1].sat !== 8'h00) begin n_bad++; $display("[TB] FAIL after_sat_flag: got %h need 00", rcv_q[1].sat); end
        end
    endtask

    task automatic test_backpressure();
        start_test();
        out_ready_i = 1'b0;
        in_0[0] = 4'd1; in_1[0] = 8'd1;
        send_beat(1'b1, 1'b0);
        in_0[0] = 4'd2;
        send_beat(1'b1, 1'b0);
        @(negedge clk);
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_ready: got %b need 0", ready_o); end
        n_cmp++; if (out_valid_o !== 1'b1) begin n_bad++; $display("[TB] FAIL bp_valid: got %b need 1", out_valid_o); end
        n_cmp++; if (out_o[0] !== 14'd1) begin n_bad++; $display("[TB] FAIL bp_hold_out: got %0d need 1", out_o[0]); end
        @(posedge clk);
        #1 in_0[0] = 4'd3;
        fork
            send_beat(1'b1, 1'b0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("[TB] FAIL bp_held_ready: got %b need 0", ready_o); end
                    n_cmp++; if (out_o[0] !== 14'd1) begin n_bad++; $display("[TB] FAIL bp_stable_out: got %0d need 1", out_o[0]); end
                end
                @(posedge clk);
                #1 out_ready_i = 1'b1;
            end
        join
        wait_results(3);
        n_cmp++; if (rcv_q.size() != 3) begin n_bad++; $display("[TB] FAIL bp_count: got %0d need 3", rcv_q.size()); end
        for (int j = 0; j < 3 && j < rcv_q.size(); j++) begin
            n_cmp++; if (rcv_q[j].acc[0] !== ACC_W'(j + 1)) begin n_bad++; $display("[TB] FAIL bp_order result %0d: got %0d need %0d", j, rcv_q[j].acc[0], j + 1); end
        end
    endtask

    task automatic test_back_to_back();
        int len;
        start_test();
        stall_cycles = 0;
        for (int g = 0; g < 20; g++) begin
            len = $urandom_range(1, 12);
            for (int b = 0; b < len; b++) begin
                for (int i = 0; i < LANES; i++) begin
                    in_0[i] = IN0'($urandom);
                    in_1[i] = IN1'($urandom);
                end
                send_beat(b == len - 1, 1'($urandom_range(0, 1)));
            end
        end
        wait_results(exp_q.size());
        n_cmp++; if (stall_cycles != 0) begin n_bad++; $display("[TB] FAIL b2b_gaps: got %0d stalled cycles need 0", stall_cycles); end
        n_cmp++; if (rcv_q.size() != exp_q.size()) begin n_bad++; $display("[TB] FAIL b2b_count: got %0d need %0d", rcv_q.size(), exp_q.size()); end
        for (int j = 0; j < exp_q.size() && j < rcv_q.size(); j++) begin
            for (int i = 0; i < LANES; i++) begin
                n_cmp++; if (rcv_q[j].acc[i] !== exp_q[j].acc[i]) begin n_bad++; $display("[TB] FAIL b2b_out group %0d lane %0d: got %0d need %0d", j, i, $signed(rcv_q[j].acc[i]), $signed(exp_q[j].acc[i])); end
            end
            n_cmp++; if (rcv_q[j].sat !== exp_q[j].sat) begin n_bad++; $display("[TB] FAIL b2b_sat group %0d: got %h need %h", j, rcv_q[j].sat, exp_q[j].sat); end
            n_cmp++; if (rcv_q[j].beats !== exp_q[j].beats) begin n_bad++; $display("[TB] FAIL b2b_beats group %0d: got %0d need %0d", j, rcv_q[j].beats, exp_q[j].beats); end
        end
    endtask

    task automatic test_beat_count();
        start_test();
        set_lanes(4'd1, 8'd1);
        for (int b = 0; b < 260; b++) send_beat(b == 259, 1'b0);
        wait_results(1);
        n_cmp++; if (rcv_q.size() != 1) begin n_bad++; $display("[TB] FAIL cnt_count: got %0d need 1", rcv_q.size()); end
        if (rcv_q.size() >= 1) begin
            n_cmp++; if (rcv_q[0].beats !== 8'd255) begin n_bad++; $display("[TB] FAIL cnt_saturate: got %0d need 255", rcv_q[0].beats); end
            n_cmp++; if (rcv_q[0].acc[0] !== 14'd260) begin n_bad++; $display("[TB] FAIL cnt_sum: got %0d need 260", rcv_q[0].acc[0]); end
            n_cmp++; if (rcv_q[0].sat !== 8'h00) begin n_bad++; $display("[TB] FAIL cnt_sat: got %h need 00", rcv_q[0].sat); end
        end
    endtask

    task automatic test_reset_mid_group();
        start_test();
        set_lanes(4'd1, 8'd1);
        for (int b = 0; b < 3; b++) send_beat(1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        rcv_q.delete();
        exp_q.delete();
        send_beat(1'b0, 1'b0);
        send_beat(1'b1, 1'b0);
        wait_results(1);
        n_cmp++; if (rcv_q.size() != 1) begin n_bad++; $display("[TB] FAIL rst_mid_count: got %0d need 1", rcv_q.size()); end
        if (rcv_q.size() >= 1) begin
            n_cmp++; if (rcv_q[0].acc[0] !== 14'd2) begin n_bad++; $display("[TB] FAIL rst_mid_out: got %0d need 2", rcv_q[0].acc[0]); end
            n_cmp++; if (rcv_q[0].beats !== 8'd2) begin n_bad++; $display("[TB] FAIL rst_mid_beats: got %0d need 2", rcv_q[0].beats); end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_single_signed();
        test_unsigned_signed();
        test_saturation();
        test_backpressure();
        test_back_to_back();
        test_beat_count();
        test_reset_mid_group();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multsigned_acc_array.md
# multsigned_acc_array

Pipelined, parametrised multiply-accumulate array. It is the successor to the combinational partial-product multiplier array. Each of SIZE_ARRAY lanes multiplies a signed or unsigned IN_SIZE_0 × IN_SIZE_1 operand pair and accumulates the full product over a variable-length group of beats into a saturating ACC_SIZE-bit accumulator. Each finished group is returned through a valid/ready output register. The block sits between the operand fetch stage and the result writeback of the AI core datapath.

## Interface
- IN_SIZE_0, 4, width of operand 0 per lane
- IN_SIZE_1, 8, width of operand 1 per lane
- SIZE_ARRAY, 8, number of lanes
- ACC_SIZE, 20, accumulator width per lane; must be ≥ IN_SIZE_0+IN_SIZE_1+2 (elaboration assertion)
- CNT_SIZE, 8, width of beat counter
- clk_i  in  1  clock; single clock domain
- rst_ni  in  1  asynchronous active-low reset
- valid_i  in  1  input beat valid
- ready_o  out  1  input beat accepted when valid_i && ready_o
- last_i  in  1  beat closes the current accumulation group
- signed_i  in  1  1: both operands two's complement; 0: both unsigned; sampled per beat
- in_0_i  in  IN_SIZE_0 × [0:SIZE_ARRAY-1]  operand 0 per lane
- in_1_i  in  IN_SIZE_1 × [0:SIZE_ARRAY-1]  operand 1 per lane
- out_valid_o  out  1  result valid
- out_ready_i  in  1  result consumed when out_valid_o && out_ready_i
- out_o  out  ACC_SIZE × [0:SIZE_ARRAY-1]  saturated group sum per lane
- sat_o  out  SIZE_ARRAY  per-lane sticky saturation flag for the reported group
- beats_o  out  CNT_SIZE  number of beats in the reported group; saturates at 2^CNT_SIZE-1

## Operation
- Stage P (product register):
  - On accept, each lane registers product = in_0 × in_1, width IN_SIZE_0+IN_SIZE_1.
  - Signed mode: sign-extend both operands. Unsigned mode: zero-extend both operands.
  - Also registers the last bit and p_vld.
- Stage A (accumulator):
  - When P advances, each lane computes acc_next = sat(acc + ext(product)). ext() sign-extends in signed mode and zero-extends in unsigned mode.
  - sat() clamps to [-2^(ACC_SIZE-1), 2^(ACC_SIZE-1)-1].
  - A clamp sets that lane's sticky sat flag.
  - The beat counter increments, saturating at 2^CNT_SIZE-1.
- On a last beat, acc_next, the sat flags and count+1 load into the output register O (o_vld=1). In the same edge the accumulator, flags and counter clear to 0. The next group starts from zero with no bubble.
- A single-beat group (last_i on its first beat) reports product alone and beats_o=1.
- P advances unless it holds a last beat while O is full and not being drained: stall = p_vld && p_last && o_vld && !out_ready_i.
- ready_o = !p_vld || !stall. This is combinational from registers and out_ready_i; it never depends on valid_i.
- If O drains and P loads O in the same edge, the new result replaces the old one with o_vld held at 1.
- Non-last beats never stall on O.
- Reset: all registers clear, including acc, flags and counter. Outputs: ready_o=1, out_valid_o=0, out_o=0, sat_o=0, beats_o=0.
- Reset mid-group discards the partial accumulation and any pending result.

## Timing
- Latency: a last beat accepted at edge k is registered in P at k, loads O at edge k+1, and out_valid_o is high in the cycle after k+1 (2 cycles).
- Throughput: 1 beat/cycle with out_ready_i=1.
- out_o, sat_o and beats_o are stable while out_valid_o && !out_ready_i.
- Under backpressure:
  - At most one finished group waits in O.
  - At most one stalled last beat waits in P.
  - ready_o drops in the cycle P holds the stalled last beat.

## Test plan
- Signed single beat, lane 0: in_0=4'b1001 (-7), in_1=8'd127, last=1 -> out_o[0]=-889 two cycles after accept; beats_o=1; sat_o=0.
- Unsigned: in_0=4'hF, in_1=8'hFF, signed_i=0 -> out_o=3825. Same operands with signed_i=1 -> out_o=+1 (-1 × -1).
- Multi-beat with saturation, ACC_SIZE=14: 8 beats of in_0=-8, in_1=-128 (1024 each), last on beat 8 -> out_o=8191, sat_o=1, beats_o=8. The next 1-beat group of 2×3 -> out_o=6, sat_o=0.
- Backpressure: out_ready_i=0, three single-beat groups A=1×1, B=2×1, C=3×1 offered back-to-back -> A in O, ready_o=0 after B reaches P, C held. Raise out_ready_i -> results 1, 2, 3 in order, none lost or duplicated.
- Back-to-back groups at full rate, random operands on all lanes, random signed_i -> every lane matches the reference model sum; no gap between groups.
- Reset asserted mid-group after 3 beats, then a new 2-beat group of 1×1 -> out_o=2, beats_o=2; no stale result emitted.
